// File: rtl/ls_preload_streamer_pkg.sv
// Shared widths, constants and FSM state type for the LocalStore preload streamer.
package ls_preload_streamer_pkg;

  localparam int WORD_W       = 32;
  localparam int QW_W         = 128;
  localparam int LS_ADDR_W    = 15;
  localparam int CNT_W        = 12;
  localparam int QW_BYTES     = 16;
  localparam int WORDS_PER_QW = QW_W / WORD_W;

  typedef enum logic [1:0] {
    PL_IDLE,
    PL_COLLECT,
    PL_WRITE,
    PL_DONE
  } pl_state_t;

endpackage

// File: rtl/ls_preload_streamer_qw_packer.sv
// Packs four stream words into a big-endian quadword; first word lands in the top slice.
module qw_packer
  import ls_preload_streamer_pkg::*;
#(
  parameter int WORD_W = ls_preload_streamer_pkg::WORD_W,
  parameter int QW_W   = ls_preload_streamer_pkg::QW_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              push,
  input  logic [WORD_W-1:0] word,
  output logic [QW_W-1:0]   qw,
  output logic              qw_full
);

  logic [1:0]      idx;
  logic [QW_W-1:0] acc;

  // qw already includes the word being pushed, so the caller can capture a
  // complete quadword on the same edge the fourth word is accepted.
  always_comb begin
    qw = acc;
    for (int unsigned k = 0; k < 4; k++) begin
      if (push && (idx == k[1:0])) begin
        qw[QW_W-1-WORD_W*k -: WORD_W] = word;
      end
    end
    qw_full = push && (idx == 2'd3);
  end

  always_ff @(posedge clk) begin
    if (!rst || clear) begin
      idx <= '0;
      acc <= '0;
    end else if (push) begin
      idx <= idx + 2'd1;
      acc <= qw;
    end
  end

endmodule

// File: rtl/ls_preload_streamer.sv
// LocalStore preload transmitter: packs a 32-bit word stream into quadwords and
// issues one aligned preload write per quadword while holding the core.
module ls_preload_streamer
  import ls_preload_streamer_pkg::*;
#(
  parameter int WORD_W    = ls_preload_streamer_pkg::WORD_W,
  parameter int QW_W      = ls_preload_streamer_pkg::QW_W,
  parameter int LS_ADDR_W = ls_preload_streamer_pkg::LS_ADDR_W,
  parameter int CNT_W     = ls_preload_streamer_pkg::CNT_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [LS_ADDR_W-1:0] base_addr,
  input  logic [CNT_W-1:0]     qw_count,
  input  logic                 abort,
  input  logic                 in_valid,
  input  logic [WORD_W-1:0]    in_data,
  output logic                 in_ready,
  output logic                 preload_LS_en,
  output logic [LS_ADDR_W-1:0] preload_LS_addr,
  output logic [QW_W-1:0]      preload_LS_data,
  output logic                 busy,
  output logic                 done,
  output logic                 core_hold,
  output logic [CNT_W-1:0]     qw_written
);

  pl_state_t            state;
  logic [LS_ADDR_W-1:0] addr;
  logic [CNT_W-1:0]     remaining;
  logic                 push;
  logic                 clear;
  logic                 idle_like;
  logic                 qw_full;
  logic [QW_W-1:0]      qw;

  always_comb begin
    idle_like = (state == PL_IDLE) || (state == PL_DONE);
    push      = (state == PL_COLLECT) && in_valid && in_ready && !abort;
    clear     = (idle_like && start && !abort) || ((state == PL_COLLECT) && abort);
  end

  qw_packer #(
    .WORD_W (WORD_W),
    .QW_W   (QW_W)
  ) u_packer (
    .clk     (clk),
    .rst     (rst),
    .clear   (clear),
    .push    (push),
    .word    (in_data),
    .qw      (qw),
    .qw_full (qw_full)
  );

  always_ff @(posedge clk) begin
    if (!rst) begin
      state           <= PL_IDLE;
      addr            <= '0;
      remaining       <= '0;
      in_ready        <= 1'b0;
      preload_LS_en   <= 1'b0;
      preload_LS_addr <= '0;
      preload_LS_data <= '0;
      busy            <= 1'b0;
      done            <= 1'b0;
      core_hold       <= 1'b0;
      qw_written      <= '0;
    end else begin
      preload_LS_en <= 1'b0;
      case (state)
        PL_IDLE, PL_DONE: begin
          if (abort) begin
            done <= 1'b0;
          end else if (start) begin
            addr       <= base_addr & ~LS_ADDR_W'(QW_BYTES - 1);
            remaining  <= qw_count;
            qw_written <= '0;
            if (qw_count == '0) begin
              state <= PL_DONE;
              done  <= 1'b1;
            end else begin
              state     <= PL_COLLECT;
              done      <= 1'b0;
              busy      <= 1'b1;
              core_hold <= 1'b1;
              in_ready  <= 1'b1;
            end
          end
        end
        PL_COLLECT: begin
          if (abort) begin
            state     <= PL_IDLE;
            busy      <= 1'b0;
            core_hold <= 1'b0;
            in_ready  <= 1'b0;
            done      <= 1'b0;
          end else if (qw_full) begin
            state           <= PL_WRITE;
            in_ready        <= 1'b0;
            preload_LS_en   <= 1'b1;
            preload_LS_addr <= addr;
            preload_LS_data <= qw;
          end
        end
        PL_WRITE: begin
          // Address wraps naturally at the LS size through the register width.
          addr       <= addr + LS_ADDR_W'(QW_BYTES);
          remaining  <= remaining - CNT_W'(1);
          qw_written <= qw_written + CNT_W'(1);
          if (remaining == CNT_W'(1)) begin
            state     <= PL_DONE;
            busy      <= 1'b0;
            core_hold <= 1'b0;
            done      <= 1'b1;
          end else if (abort) begin
            state     <= PL_IDLE;
            busy      <= 1'b0;
            core_hold <= 1'b0;
          end else begin
            state    <= PL_COLLECT;
            in_ready <= 1'b1;
          end
        end
        default: state <= PL_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_ls_preload_streamer.sv
// Directed bench for ls_preload_streamer: a quadword-level write model plus literal checks.
module tb_ls_preload_streamer;

  logic         clk;
  logic         rst;
  logic         start;
  logic [14:0]  base_addr;
  logic [11:0]  qw_count;
  logic         abort;
  logic         in_valid;
  logic [31:0]  in_data;
  logic         in_ready;
  logic         preload_LS_en;
  logic [14:0]  preload_LS_addr;
  logic [127:0] preload_LS_data;
  logic         busy;
  logic         done;
  logic         core_hold;
  logic [11:0]  qw_written;

  ls_preload_streamer dut (
    .clk             (clk),
    .rst             (rst),
    .start           (start),
    .base_addr       (base_addr),
    .qw_count        (qw_count),
    .abort           (abort),
    .in_valid        (in_valid),
    .in_data         (in_data),
    .in_ready        (in_ready),
    .preload_LS_en   (preload_LS_en),
    .preload_LS_addr (preload_LS_addr),
    .preload_LS_data (preload_LS_data),
    .busy            (busy),
    .done            (done),
    .core_hold       (core_hold),
    .qw_written      (qw_written)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [14:0]  a;
    logic [127:0] d;
  } wr_t;

  logic [31:0] src[$];
  wr_t         exp_q[$];
  int          tests    = 0;
  int          fails    = 0;
  int          en_count = 0;
  bit          chk_on   = 1'b0;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Expected writes: quadword q goes to the aligned base plus 16*q (mod 32 KB)
  // and carries stream words 4q..4q+3, first word most significant.
  task automatic plan(input logic [14:0] base, input int n);
    wr_t         w;
    logic [14:0] a;
    a = base & 15'h7FF0;
    for (int q = 0; q < n; q++) begin
      w.a = a + 15'(16 * q);
      w.d = {src[4*q], src[4*q+1], src[4*q+2], src[4*q+3]};
      exp_q.push_back(w);
    end
  endtask

  task automatic add_words(input logic [31:0] first, input int n);
    for (int i = 0; i < n; i++) src.push_back(first + 32'(i));
  endtask

  task automatic pulse_start(input logic [14:0] base, input logic [11:0] cnt);
    start     = 1'b1;
    base_addr = base;
    qw_count  = cnt;
    @(negedge clk);
    start = 1'b0;
  endtask

  // Holds in_valid high continuously; a word is consumed only when in_ready is seen.
  task automatic feed(input int n);
    int sent = 0;
    int cyc  = 0;
    while (sent < n && cyc < 200) begin
      in_valid = 1'b1;
      if (in_ready) begin
        in_data = src.pop_front();
        sent++;
      end else begin
        in_data = src[0];
      end
      @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0;
    if (sent < n) check("feed_timeout", 128'(sent), 128'(n));
  endtask

  task automatic wait_done(output logic hold_before);
    logic prev;
    prev        = core_hold;
    hold_before = 1'b0;
    for (int i = 0; i < 50; i++) begin
      if (done) begin
        hold_before = prev;
        return;
      end
      prev = core_hold;
      @(negedge clk);
    end
    check("done_timeout", 128'(done), 128'(1));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_in_ready"},  128'(in_ready),        128'(0));
    check({tag, "_en"},        128'(preload_LS_en),   128'(0));
    check({tag, "_addr"},      128'(preload_LS_addr), 128'(0));
    check({tag, "_data"},      preload_LS_data,       128'(0));
    check({tag, "_busy"},      128'(busy),            128'(0));
    check({tag, "_done"},      128'(done),            128'(0));
    check({tag, "_core_hold"}, 128'(core_hold),       128'(0));
    check({tag, "_qw_written"},128'(qw_written),      128'(0));
  endtask

  // Per-cycle compare against the write model and the handshake rules.
  always @(negedge clk) begin
    if (chk_on) begin
      if (preload_LS_en) begin
        wr_t w;
        en_count++;
        if (exp_q.size() == 0) begin
          tests++;
          fails++;
          $display("FAIL unexpected_write: got addr %h data %h, expected no write",
                   preload_LS_addr, preload_LS_data);
        end else begin
          w = exp_q.pop_front();
          check("wr_addr", 128'(preload_LS_addr), 128'(w.a));
          check("wr_data", preload_LS_data, w.d);
        end
      end
      check("in_ready_rule", 128'(in_ready), 128'(busy && !preload_LS_en));
      check("core_hold_rule", 128'(core_hold), 128'(busy));
      check("done_busy_excl", 128'(done && busy), 128'(0));
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected bench completion");
    $fatal(1);
  end

  initial begin
    logic hb;
    rst = 1'b0; start = 1'b0; base_addr = '0; qw_count = '0;
    abort = 1'b0; in_valid = 1'b0; in_data = '0;
    @(negedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst    = 1'b1;
    chk_on = 1'b1;
    @(negedge clk);

    // Single quadword
    src.push_back(32'h11111111); src.push_back(32'h22222222);
    src.push_back(32'h33333333); src.push_back(32'h44444444);
    plan(15'h0100, 1);
    check("model_pin_addr", 128'(exp_q[0].a), 128'(15'h0100));
    check("model_pin_data", exp_q[0].d, 128'h11111111_22222222_33333333_44444444);
    pulse_start(15'h0100, 12'd1);
    feed(4);
    wait_done(hb);
    check("t1_hold_before_done", 128'(hb), 128'(1));
    check("t1_core_hold", 128'(core_hold), 128'(0));
    check("t1_qw_written", 128'(qw_written), 128'(1));
    check("t1_held_data", preload_LS_data, 128'h11111111_22222222_33333333_44444444);

    // Streaming three quadwords
    add_words(32'hA0000000, 12);
    plan(15'h0000, 3);
    pulse_start(15'h0000, 12'd3);
    feed(12);
    wait_done(hb);
    check("t2_qw_written", 128'(qw_written), 128'(3));
    check("t2_en_count", 128'(en_count), 128'(4));

    // Alignment and wrap
    add_words(32'hB0000000, 8);
    plan(15'h7FF7, 2);
    check("model_pin_wrap0", 128'(exp_q[0].a), 128'(15'h7FF0));
    check("model_pin_wrap1", 128'(exp_q[1].a), 128'(15'h0000));
    pulse_start(15'h7FF7, 12'd2);
    feed(8);
    wait_done(hb);
    check("t3_last_addr", 128'(preload_LS_addr), 128'(15'h0000));

    // Zero count, then start ignored while busy
    pulse_start(15'h0440, 12'd0);
    check("t4_zero_done", 128'(done), 128'(1));
    check("t4_zero_busy", 128'(busy), 128'(0));
    check("t4_zero_written", 128'(qw_written), 128'(0));
    add_words(32'hC0000000, 8);
    plan(15'h0200, 2);
    pulse_start(15'h0200, 12'd2);
    check("t4_done_cleared", 128'(done), 128'(0));
    feed(2);
    pulse_start(15'h1000, 12'd5);
    feed(6);
    wait_done(hb);
    check("t4_qw_written", 128'(qw_written), 128'(2));

    // Abort two words into the second quadword
    add_words(32'hD0000000, 6);
    plan(15'h0300, 1);
    pulse_start(15'h0300, 12'd2);
    feed(6);
    abort = 1'b1;
    @(negedge clk);
    abort = 1'b0;
    check("t5_busy", 128'(busy), 128'(0));
    check("t5_done", 128'(done), 128'(0));
    check("t5_in_ready", 128'(in_ready), 128'(0));
    check("t5_qw_written", 128'(qw_written), 128'(1));
    repeat (3) @(negedge clk);
    add_words(32'hE0000000, 4);
    plan(15'h0400, 1);
    pulse_start(15'h0400, 12'd1);
    feed(4);
    wait_done(hb);
    check("t5_restart_written", 128'(qw_written), 128'(1));
    check("t5_restart_data", preload_LS_data,
          128'hE0000000_E0000001_E0000002_E0000003);

    // Reset mid-load with three words accepted
    add_words(32'hF0000000, 3);
    pulse_start(15'h0500, 12'd1);
    feed(3);
    rst = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    check_all_zero("midreset");

    // start and abort together in IDLE
    start = 1'b1; abort = 1'b1; base_addr = 15'h0600; qw_count = 12'd1;
    @(negedge clk);
    start = 1'b0; abort = 1'b0;
    check("t6_sa_busy", 128'(busy), 128'(0));
    check("t6_sa_done", 128'(done), 128'(0));
    check("t6_sa_in_ready", 128'(in_ready), 128'(0));
    repeat (4) @(negedge clk);

    check("exp_q_drained", 128'(exp_q.size()), 128'(0));
    check("total_writes", 128'(en_count), 128'(10));
    chk_on = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/ls_preload_streamer.md
Name: ls_preload_streamer

Overview:
- Transmitter side of the LocalStore preload interface (preload_LS_en / preload_LS_addr / preload_LS_data) consumed by the odd pipe's LocalStore.
- Accepts a 32-bit word stream from the host/testbench loader over a valid/ready handshake, packs it into big-endian 128-bit quadwords, and issues one preload write per quadword at consecutive quadword-aligned LS byte addresses.
- Holds the core (core_hold) while a load is in progress so no stqa/stqd or load races the preload.

Parameters:
- WORD_W, 32, input stream word width
- QW_W, 128, quadword width (= 4 × WORD_W, fixed)
- LS_ADDR_W, 15, LocalStore byte-address width (32 KB)
- CNT_W, 12, quadword-count width (max 2048 quadwords = full LS)

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-low
- start  in  1  one-cycle load request
- base_addr  in  [0:14]  starting LS byte address; bits [11:14] ignored (forced 0)
- qw_count  in  [0:11]  number of quadwords to write; 0 is legal
- abort  in  1  cancel current load
- in_valid  in  1  stream word valid
- in_data  in  [0:31]  stream word
- in_ready  out  1  streamer can accept a word
- preload_LS_en  out  1  one-cycle LS write strobe
- preload_LS_addr  out  [0:14]  LS byte address, quadword aligned
- preload_LS_data  out  [0:127]  quadword; first received word at bits [0:31]
- busy  out  1  load in progress
- done  out  1  level; last load completed normally
- core_hold  out  1  stall request to the SPU front end
- qw_written  out  [0:11]  quadwords written in current/last load

Behaviour:
- All outputs registered. On rst==0 at a clock edge: state IDLE; in_ready, preload_LS_en, busy, done, core_hold = 0; preload_LS_addr, preload_LS_data, qw_written = 0; internal word index and remaining count = 0. Reset mid-load drops the partial quadword; no write is issued.
- States: IDLE, COLLECT, WRITE, DONE.
- IDLE/DONE: start==1 and abort==0 latches base_addr (low 4 bits zeroed), sets remaining = qw_count, clears qw_written and done.
  - If qw_count==0, go to DONE: done=1 the next cycle, with no write and no busy.
  - Otherwise go to COLLECT: busy=1, core_hold=1, in_ready=1 from the next cycle.
- COLLECT: a word is accepted when in_valid && in_ready.
  - Word index k (0..3) is placed at bits [32k : 32k+31].
  - On acceptance of the k=3 word: preload_LS_data is loaded with the full quadword, preload_LS_addr is loaded with the current address, and the state goes to WRITE. in_ready drops in that same registered update.
- WRITE (exactly one cycle): preload_LS_en=1 and in_ready=0.
  - Address advances by 16, modulo 2^15 (0x7FF0 → 0x0000). remaining decrements; qw_written increments.
  - If remaining becomes 0: go to DONE with busy=0, core_hold=0, done=1.
  - Otherwise: go to COLLECT with in_ready=1.
- Throughput: 4 words per 5 cycles with continuous in_valid.
- preload_LS_en is never asserted outside WRITE. addr/data hold their last values when en=0.
- DONE: done stays high until the next accepted start or reset.
- abort:
  - In COLLECT: discard the partial quadword and go to IDLE. busy, core_hold, in_ready and done all = 0; qw_written is retained.
  - In WRITE: the write in that cycle completes, then go to IDLE.
  - In IDLE/DONE: clears done. If start and abort arrive together, abort wins.
- start while busy is ignored; there is no queueing.
- in_valid while in_ready==0 is ignored (the word is not consumed).

Decomposition:
- Shared package (e.g. alongside opcode_package.vh), as `define constants:
  - state encodings PL_IDLE/PL_COLLECT/PL_WRITE/PL_DONE
  - LS_ADDR_W, QW_W
  - QW_BYTES=16
- One sub-module, qw_packer: word index counter plus a 128-bit shift/placement register.
  - Inputs: clk, rst, clear, push, word.
  - Outputs: qw, qw_full.
- The FSM, address/count logic and output registers live in ls_preload_streamer.

Test Plan:
- Single quadword: base_addr=0x0100, qw_count=1, words 0x11111111, 0x22222222, 0x33333333, 0x44444444 → one en pulse with addr 0x0100, data 0x11111111_22222222_33333333_44444444; done=1; core_hold falls the same cycle done rises; qw_written=1.
- Streaming: qw_count=3 with in_valid held high → en pulses at addrs 0x0000, 0x0010, 0x0020. in_ready is low exactly in each WRITE cycle, and no word is lost or duplicated.
- Alignment and wrap: base_addr=0x7FF7, qw_count=2 → writes at 0x7FF0 then 0x0000.
- Zero count and ignored start: qw_count=0 → done=1 one cycle after start, en never asserted. A second start pulse while busy does not change remaining or the address.
- Abort: abort after 2 words of the second quadword → no second write, IDLE, qw_written=1, done=0. A following start runs cleanly from word index 0.
- Reset mid-load: rst=0 for one cycle in COLLECT with 3 words accepted → all outputs zero next cycle and no en pulse. Also check that start+abort in the same cycle in IDLE is a no-op.
